// File: rtl/his_acq_scheduler_pkg.sv
// Shared definitions for the histogram acquisition scheduler: default
// geometry, FSM state encoding and the clear-origin flag.
package his_acq_scheduler_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_SEL_W     = 2;
    localparam int DEF_NB        = 8;
    localparam int DEF_ACQ_NUM   = 1024;
    localparam int DEF_ACQ_W     = 17;
    localparam int DEF_FRM_W     = 9;
    localparam int DEF_DRAIN_CYC = 2;

    // Frame sequencing states; IDLE is all-zero so a reset state reads as 0.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACQ   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_READ  = 3'd4
    } state_e;

    // Value of the clear-origin flag when the running CLEAR closes a frame
    // (it was entered from READ rather than from IDLE).
    localparam logic CLR_FROM_READ = 1'b1;

endpackage

// File: rtl/his_acq_scheduler_if.sv
// Requester and histogram-bank bus of the acquisition scheduler.
//
// Handshakes:
//   req_valid[i]/req_ready[i]: requester i presents req_bin slice i with
//   req_valid high and holds both until a cycle where req_ready[i] is also
//   high; that cycle transfers the event. req_ready is one-hot or zero.
//   rd_ready: the bank readout consumer accepts one word in each cycle it is
//   high; the scheduler issues hb_rd_en for exactly those cycles, one cycle
//   later on the registered hb_* outputs.
interface his_acq_scheduler_if
    import his_acq_scheduler_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int NB    = DEF_NB,
    parameter int SEL_W = DEF_SEL_W
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*NB-1:0] req_bin;
    logic [N_REQ-1:0]    req_ready;
    logic                hb_wr_en;
    logic                hb_rd_en;
    logic                hb_clr_en;
    logic [SEL_W-1:0]    hb_sel;
    logic [NB-1:0]       hb_addr;
    logic                rd_ready;

    // Scheduler side.
    modport master (
        input  req_valid, req_bin, rd_ready,
        output req_ready, hb_wr_en, hb_rd_en, hb_clr_en, hb_sel, hb_addr
    );

    // Requesters / histogram banks / readout side.
    modport slave (
        output req_valid, req_bin, rd_ready,
        input  req_ready, hb_wr_en, hb_rd_en, hb_clr_en, hb_sel, hb_addr
    );
endinterface

// File: rtl/his_acq_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter. The caller owns the pointer and moves
// it to winner+1 whenever gnt_vld is high; N_REQ must be a power of two so
// the index arithmetic wraps naturally.
module his_acq_scheduler_rr_arbiter
    import his_acq_scheduler_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             adv_en,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [SEL_W-1:0] idx;

    // Scan from the pointer upward and take the first active request.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (adv_en && !gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt_idx  = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/his_acq_scheduler.sv
// Histogram acquisition scheduler: runs each frame through
// CLEAR -> ACQ -> DRAIN -> READ -> CLEAR, arbitrating TDC bin events onto
// the single bank write port during ACQ and sweeping every bank/bin for
// readout and clearing. All hb_* commands are registered (one cycle after
// the decision) and at most one of wr/rd/clr is high in any cycle.
module his_acq_scheduler
    import his_acq_scheduler_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int NB        = DEF_NB,
    parameter int ACQ_NUM   = DEF_ACQ_NUM,
    parameter int ACQ_W     = DEF_ACQ_W,
    parameter int FRM_W     = DEF_FRM_W,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 laser_sync,
    his_acq_scheduler_if.master  bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic [FRM_W-1:0]     frame_cnt,
    output state_e               state_dbg
);

    localparam int SWP_W = SEL_W + NB;
    localparam int DRN_W = $clog2(DRAIN_CYC + 1);
    localparam logic [SWP_W-1:0] SWP_LAST = '1;

    state_e             state_q, state_d;
    logic [SWP_W-1:0]   swp_q, swp_d;
    logic               clr_from_read_q, clr_from_read_d;
    logic [ACQ_W-1:0]   acq_cnt_q, acq_cnt_d;
    logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [FRM_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               frame_done_q, frame_done_d;
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic               clr_q, clr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NB-1:0]      addr_q, addr_d;

    logic [N_REQ-1:0]   gnt;
    logic [SEL_W-1:0]   gnt_idx;
    logic               gnt_vld;

    // Arbitration is only live while acquiring, so req_ready is zero elsewhere.
    his_acq_scheduler_rr_arbiter #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .adv_en  (state_q == ST_ACQ),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign bus.req_ready = gnt;
    assign bus.hb_wr_en  = wr_q;
    assign bus.hb_rd_en  = rd_q;
    assign bus.hb_clr_en = clr_q;
    assign bus.hb_sel    = sel_q;
    assign bus.hb_addr   = addr_q;
    assign busy          = (state_q != ST_IDLE);
    assign frame_done    = frame_done_q;
    assign frame_cnt     = frame_cnt_q;
    assign state_dbg     = state_q;

    // Next-state, counter and registered-command decode.
    always_comb begin
        state_d         = state_q;
        swp_d           = swp_q;
        clr_from_read_d = clr_from_read_q;
        acq_cnt_d       = acq_cnt_q;
        drain_cnt_d     = drain_cnt_q;
        rr_ptr_d        = rr_ptr_q;
        frame_cnt_d     = frame_cnt_q;
        frame_done_d    = 1'b0;
        wr_d            = 1'b0;
        rd_d            = 1'b0;
        clr_d           = 1'b0;
        sel_d           = '0;
        addr_d          = '0;

        case (state_q)
            ST_IDLE: begin
                // Every run opens with a full clear that does not count as a frame.
                if (start) begin
                    state_d         = ST_CLEAR;
                    swp_d           = '0;
                    clr_from_read_d = 1'b0;
                end
            end

            ST_CLEAR: begin
                clr_d           = 1'b1;
                {sel_d, addr_d} = swp_q;
                if (swp_q == SWP_LAST) begin
                    swp_d           = '0;
                    clr_from_read_d = 1'b0;
                    if (clr_from_read_q == CLR_FROM_READ) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 1'b1;
                    end
                    state_d = stop ? ST_IDLE : ST_ACQ;
                end else begin
                    swp_d = swp_q + 1'b1;
                end
            end

            ST_ACQ: begin
                // The grant in the window-closing cycle is still honoured.
                if (gnt_vld) begin
                    wr_d     = 1'b1;
                    sel_d    = gnt_idx;
                    addr_d   = bus.req_bin[gnt_idx*NB +: NB];
                    rr_ptr_d = gnt_idx + 1'b1;
                end
                if (laser_sync) begin
                    if (acq_cnt_q == ACQ_W'(ACQ_NUM - 1)) begin
                        acq_cnt_d   = '0;
                        drain_cnt_d = '0;
                        state_d     = ST_DRAIN;
                    end else begin
                        acq_cnt_d = acq_cnt_q + 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                // Give the bank's read-modify-write pipeline time to retire.
                if (drain_cnt_q == DRN_W'(DRAIN_CYC - 1)) begin
                    drain_cnt_d = '0;
                    swp_d       = '0;
                    state_d     = ST_READ;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end

            ST_READ: begin
                // The sweep only moves on cycles the consumer accepts a word.
                if (bus.rd_ready) begin
                    rd_d            = 1'b1;
                    {sel_d, addr_d} = swp_q;
                    if (swp_q == SWP_LAST) begin
                        swp_d           = '0;
                        clr_from_read_d = CLR_FROM_READ;
                        state_d         = ST_CLEAR;
                    end else begin
                        swp_d = swp_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any sweep in progress.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q         <= ST_IDLE;
            swp_q           <= '0;
            clr_from_read_q <= 1'b0;
            acq_cnt_q       <= '0;
            drain_cnt_q     <= '0;
            rr_ptr_q        <= '0;
            frame_cnt_q     <= '0;
            frame_done_q    <= 1'b0;
            wr_q            <= 1'b0;
            rd_q            <= 1'b0;
            clr_q           <= 1'b0;
            sel_q           <= '0;
            addr_q          <= '0;
        end else begin
            state_q         <= state_d;
            swp_q           <= swp_d;
            clr_from_read_q <= clr_from_read_d;
            acq_cnt_q       <= acq_cnt_d;
            drain_cnt_q     <= drain_cnt_d;
            rr_ptr_q        <= rr_ptr_d;
            frame_cnt_q     <= frame_cnt_d;
            frame_done_q    <= frame_done_d;
            wr_q            <= wr_d;
            rd_q            <= rd_d;
            clr_q           <= clr_d;
            sel_q           <= sel_d;
            addr_q          <= addr_d;
        end
    end

endmodule
